pb_capture: RTL and testbench

Front-end stage of the switch-compare design. It synchronises and debounces the push button `PB` and emits exactly one single-cycle `press` strobe per physical press. On that strobe it samples the two 9-bit active-low position switches `a` and `b`, encodes each as a digit 1–9, and flags malformed switch patterns. The comparator/display `top` logic consumes its registered outputs instead of raw `PB`/`a`/`b`.

---
 rtl/pb_capture_pkg.sv | 19 +
 rtl/pb_capture_onecold_enc.sv | 28 ++
 rtl/pb_capture.sv | 113 +++++++++++
 tb/tb_pb_capture.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pb_capture_pkg.sv
// Shared types and constants for the push-button capture front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pb_capture_pkg;

    localparam int CODE_W       = 4;
    localparam int SW_W         = 9;
    localparam int DB_CYCLES_DF = 20;

    localparam logic [CODE_W-1:0] CODE_INVALID = '0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } state_t;

endpackage

// File: rtl/pb_capture_onecold_enc.sv
// One-cold switch encoder: bit i low (all others high) gives digit i+1.
// Latency: combinational.
// Backpressure: none; any other pattern gives CODE_INVALID and valid=0.
module onecold_enc
    import pb_capture_pkg::*;
(
    input  logic [SW_W-1:0]   sw,
    output logic [CODE_W-1:0] code,
    output logic              valid
);

    // Count the low bits and remember where the last one sits.
    always_comb begin
        logic [3:0]        zeros;
        logic [CODE_W-1:0] pos;
        zeros = '0;
        pos   = '0;
        for (int i = 0; i < SW_W; i++) begin
            if (!sw[i]) begin
                zeros = zeros + 4'd1;
                pos   = CODE_W'(i + 1);
            end
        end
        valid = (zeros == 4'd1);
        code  = valid ? pos : CODE_INVALID;
    end

endmodule

// File: rtl/pb_capture.sv
// Synchronise and debounce PB, emit one press strobe per press, capture encoded switches.
// Latency: press and codes appear DB_CYCLES+2 cycles after PB is first sampled high.
// Backpressure: none; switch values are only looked at on the capture edge.
module pb_capture
    import pb_capture_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PB,
    input  logic [SW_W-1:0]   a,
    input  logic [SW_W-1:0]   b,
    output logic              press,
    output logic [CODE_W-1:0] a_code,
    output logic [CODE_W-1:0] b_code,
    output logic              code_vld,
    output logic              err
);

    localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

    logic              pb_m;
    logic              pb_s;
    state_t            state;
    state_t            state_nxt;
    logic [7:0]        cnt;
    logic [7:0]        cnt_nxt;
    logic              capture;
    logic [CODE_W-1:0] a_enc;
    logic [CODE_W-1:0] b_enc;
    logic              a_ok;
    logic              b_ok;

    onecold_enc u_enc_a (.sw(a), .code(a_enc), .valid(a_ok));
    onecold_enc u_enc_b (.sw(b), .code(b_enc), .valid(b_ok));

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk) begin
        if (rst) begin
            pb_m <= 1'b0;
            pb_s <= 1'b0;
        end else begin
            pb_m <= PB;
            pb_s <= pb_m;
        end
    end

    // Debounce next-state: count stable cycles, restart on any disagreement.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pb_s) begin
                    state_nxt = DB_PRESS;
                    cnt_nxt   = '0;
                end
            end
            DB_PRESS: begin
                if (!pb_s) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                end
            end
            HELD: begin
                if (!pb_s) begin
                    state_nxt = DB_REL;
                    cnt_nxt   = '0;
                end
            end
            DB_REL: begin
                if (pb_s) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counter, strobe and captured codes; reset wins over a capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            press    <= 1'b0;
            a_code   <= CODE_INVALID;
            b_code   <= CODE_INVALID;
            code_vld <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= capture;
            if (capture) begin
                a_code   <= a_enc;
                b_code   <= b_enc;
                code_vld <= 1'b1;
                err      <= !(a_ok && b_ok);
            end
        end
    end

endmodule

// File: tb/tb_pb_capture.sv
// Directed bench for pb_capture: capture table plus debounce/reset corner sequences.
// Latency: expects press DB+3 edges after PB is driven high between edges.
// Backpressure: n/a.
module tb_pb_capture;

    localparam int DB  = 20;
    localparam int LAT = DB + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       PB;
    logic [8:0] a;
    logic [8:0] b;
    logic       press;
    logic [3:0] a_code;
    logic [3:0] b_code;
    logic       code_vld;
    logic       err;

    int checks = 0;
    int errors = 0;
    int press_cnt = 0;
    int consec = 0;
    logic prev_press = 1'b0;

    pb_capture #(.DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .PB(PB), .a(a), .b(b),
        .press(press), .a_code(a_code), .b_code(b_code),
        .code_vld(code_vld), .err(err)
    );

    always #5 clk = ~clk;

    // Count strobes and catch back-to-back strobes.
    always @(negedge clk) begin
        if (press) press_cnt++;
        if (press && prev_press) consec++;
        prev_press = press;
    end

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic [3:0] ea;
        logic [3:0] eb;
        logic       eerr;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Raise PB and count edges until press shows; 0 means it never came.
    task automatic do_press(output int lat);
        lat = 0;
        PB = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (press) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_release();
        PB = 1'b0;
        for (int i = 0; i < DB + 6; i++) tick();
    endtask

    vec_t vt[$];
    int   lat;
    int   pc;

    initial begin
        vt.push_back('{9'b111111011, 9'b111101111, 4'd3, 4'd5, 1'b0});
        vt.push_back('{9'b111111110, 9'b101111111, 4'd1, 4'd8, 1'b0});
        vt.push_back('{9'b111111111, 9'b110111111, 4'd0, 4'd7, 1'b1});
        vt.push_back('{9'b111111101, 9'b011111111, 4'd2, 4'd9, 1'b0});
        vt.push_back('{9'b111110111, 9'b111111100, 4'd4, 4'd0, 1'b1});
        vt.push_back('{9'b111011111, 9'b111111111, 4'd6, 4'd0, 1'b1});
        vt.push_back('{9'b000000000, 9'b111011111, 4'd0, 4'd6, 1'b1});
        vt.push_back('{9'b011111111, 9'b111110111, 4'd9, 4'd4, 1'b0});

        rst = 1'b1;
        PB  = 1'b0;
        a   = 9'h1FF;
        b   = 9'h1FF;
        tick();
        tick();
        check("rst_press", press, 0);
        check("rst_a_code", a_code, 0);
        check("rst_b_code", b_code, 0);
        check("rst_code_vld", code_vld, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // Capture table: one press per entry, release must not strobe.
        foreach (vt[i]) begin
            a = vt[i].a;
            b = vt[i].b;
            pc = press_cnt;
            do_press(lat);
            check($sformatf("tbl%0d_latency", i), lat, LAT);
            check($sformatf("tbl%0d_a_code", i), a_code, vt[i].ea);
            check($sformatf("tbl%0d_b_code", i), b_code, vt[i].eb);
            check($sformatf("tbl%0d_err", i), err, vt[i].eerr);
            check($sformatf("tbl%0d_code_vld", i), code_vld, 1);
            for (int j = 0; j < 30; j++) tick();
            do_release();
            check($sformatf("tbl%0d_press_count", i), press_cnt - pc, 1);
        end

        // Short glitch: too short to be accepted, outputs keep last capture.
        a = 9'b111111110;
        b = 9'b111111110;
        pc = press_cnt;
        PB = 1'b1;
        for (int i = 0; i < DB - 5; i++) tick();
        do_release();
        check("glitch_no_press", press_cnt - pc, 0);
        check("glitch_a_hold", a_code, 4'd9);
        check("glitch_b_hold", b_code, 4'd4);

        // Bounce inside a press: timing restarts from the last low.
        pc = press_cnt;
        PB = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        PB = 1'b0;
        tick();
        do_press(lat);
        check("bounce_latency", lat, LAT);
        check("bounce_a_code", a_code, 4'd1);
        do_release();
        check("bounce_press_count", press_cnt - pc, 1);

        // Long hold with a switch change after capture.
        a = 9'b111111011;
        b = 9'b111101111;
        pc = press_cnt;
        do_press(lat);
        check("hold_latency", lat, LAT);
        a = 9'b101111111;
        for (int i = 0; i < 1000; i++) tick();
        check("hold_a_unchanged", a_code, 4'd3);
        check("hold_err", err, 0);
        do_release();
        check("hold_press_count", press_cnt - pc, 1);

        // Reset ten cycles into debounce, button still held.
        PB = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_press", press, 0);
        check("mid_rst_a_code", a_code, 0);
        check("mid_rst_b_code", b_code, 0);
        check("mid_rst_code_vld", code_vld, 0);
        check("mid_rst_err", err, 0);
        rst = 1'b0;
        do_press(lat);
        check("post_rst_latency", lat, LAT);
        check("post_rst_a_code", a_code, 4'd8);
        check("post_rst_code_vld", code_vld, 1);
        tick();
        check("strobe_one_cycle", press, 0);
        do_release();

        check("no_consecutive_press", consec, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
